// File: rtl/coeff_pkg.sv
// coeff_pkg: shared FSM states, default parameters and coefficient type for coeff_bank
package coeff_pkg;
  localparam int DEF_NUM_BANDS = 3;
  localparam int DEF_NUM_TAPS = 101;
  localparam int DEF_COEFF_W = 16;
  localparam int DEF_CENTER_VAL = 16384;
  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;
  typedef logic signed [DEF_COEFF_W-1:0] coeff_t;
endpackage

// File: rtl/coeff_copy_ctr.sv
// coeff_copy_ctr: band-major copy address walker with last-word flag
module coeff_copy_ctr import coeff_pkg::*; #(
  parameter int NUM_BANDS = DEF_NUM_BANDS,
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int BW = 2,
  parameter int IW = 7
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [BW-1:0] band,
  output logic [IW-1:0] index,
  output logic          last
);
  logic idx_end, band_end;
  assign idx_end = index == IW'(NUM_TAPS - 1);
  assign band_end = band == BW'(NUM_BANDS - 1);
  assign last = idx_end && band_end;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      band <= '0;
      index <= '0;
    end else if (en) begin
      index <= idx_end ? '0 : index + 1'b1;
      band <= last ? '0 : idx_end ? band + 1'b1 : band;
    end
endmodule

// File: rtl/coeff_bank.sv
// coeff_bank: double-buffered filter coefficients; writes go to SHADOW, a commit
// swaps banks on the next sample_tick, then COPY resynchronises the new SHADOW.
module coeff_bank import coeff_pkg::*; #(
  parameter int NUM_BANDS = DEF_NUM_BANDS,
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int COEFF_W = DEF_COEFF_W,
  parameter int CENTER_VAL = DEF_CENTER_VAL,
  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1,
  localparam int IW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [BW-1:0]             wr_band,
  input  logic [IW-1:0]             wr_index,
  input  logic signed [COEFF_W-1:0] wr_data,
  input  logic                      commit_req,
  input  logic                      sample_tick,
  input  logic [BW-1:0]             rd_band,
  input  logic [IW-1:0]             rd_index,
  output logic signed [COEFF_W-1:0] rd_data,
  output logic                      busy,
  output logic                      commit_done,
  output logic                      addr_err
);
  localparam int CTR = (NUM_TAPS - 1) / 2;
  logic signed [COEFF_W-1:0] bank [2][NUM_BANDS][NUM_TAPS];
  state_t state, state_d;
  logic act_sel, swap, wr_ok, wr_inr, rd_inr, rd_sel, last;
  logic [BW-1:0] cp_band;
  logic [IW-1:0] cp_index;
  coeff_copy_ctr #(.NUM_BANDS(NUM_BANDS), .NUM_TAPS(NUM_TAPS), .BW(BW), .IW(IW)) u_ctr (
    .clk(clk), .rst_n(rst_n), .en(state == COPY),
    .band(cp_band), .index(cp_index), .last(last)
  );
  assign swap = state == PENDING && sample_tick;
  assign wr_ok = wr_valid && wr_ready;
  assign wr_inr = int'(wr_band) < NUM_BANDS && int'(wr_index) < NUM_TAPS;
  assign rd_inr = int'(rd_band) < NUM_BANDS && int'(rd_index) < NUM_TAPS;
  // read through the post-swap select so the new set appears right after the tick
  assign rd_sel = act_sel ^ swap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb
    state_d = (state == IDLE && commit_req) ? PENDING :
              swap ? COPY :
              (state == COPY && last) ? IDLE : state;
  always_comb begin
    wr_ready = state == IDLE;
    busy = state != IDLE;
    commit_done = state == COPY && last;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act_sel <= 1'b0;
      addr_err <= 1'b0;
      rd_data <= '0;
    end else begin
      act_sel <= act_sel ^ swap;
      addr_err <= addr_err | (wr_ok && !wr_inr);
      rd_data <= rd_inr ? bank[rd_sel][rd_band][rd_index] : '0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int s = 0; s < 2; s++)
        for (int b = 0; b < NUM_BANDS; b++)
          for (int t = 0; t < NUM_TAPS; t++)
            bank[s][b][t] <= (t == CTR) ? COEFF_W'(CENTER_VAL) : '0;
    end else if (state == COPY)
      bank[~act_sel][cp_band][cp_index] <= bank[act_sel][cp_band][cp_index];
    else if (wr_ok && wr_inr)
      bank[~act_sel][wr_band][wr_index] <= wr_data;
endmodule
